// File: rtl/flexbex_bus_pkg.sv
// Shared types and constants for the flexbex core-to-Wishbone bridge.
// Imported by the bridge top, its arbiter and the bench.
package flexbex_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic PORT_INSTR = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam logic [3:0]  SEL_ALL   = 4'hF;
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_req_t;

    function automatic logic [31:0] word_adr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic int unsigned wdog_width(input int unsigned t);
        return (t <= 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/flexbex_wb_bridge_if.sv
// Signal bundle of the bridge: core instr/data ports plus the Wishbone master.
// master = the bridge itself; slave = core and interconnect side.
interface flexbex_wb_bridge_if;

    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;

    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i,
        input  data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o,
        output data_rdata_o, data_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o,
        output wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i,
        output data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o,
        input  data_rdata_o, data_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o,
        input  wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );

endinterface

// File: rtl/flexbex_rr_arb2.sv
// Two-requester round-robin arbiter with a fixed-priority override.
// Bit 0 = instr, bit 1 = data; pointer moves only on an accepted grant.
module flexbex_rr_arb2
    import flexbex_bus_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       prio_i,
    input  logic       gnt_stb_i,
    output logic [1:0] gnt_o
);

    // ptr_q names the port that wins the next conflict
    logic ptr_q;

    always_comb begin
        gnt_o = 2'b00;
        unique case (1'b1)
            (req_i == 2'b11):
                gnt_o = (prio_i || ptr_q == PORT_DATA) ? 2'b10 : 2'b01;
            (req_i == 2'b01):
                gnt_o = 2'b01;
            (req_i == 2'b10):
                gnt_o = 2'b10;
            default:
                gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PORT_INSTR;
        end else if (gnt_stb_i) begin
            ptr_q <= gnt_o[0] ? PORT_DATA : PORT_INSTR;
        end
    end

endmodule

// File: rtl/flexbex_wb_bridge.sv
// Merges the flexbex instr and data ports onto one Wishbone classic master.
// One transaction in flight; a watchdog turns hung cycles into errors.
module flexbex_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          DATA_PRIORITY  = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    flexbex_wb_bridge_if.master bus
);

    import flexbex_bus_pkg::*;

    localparam int unsigned WDW     = wdog_width(TIMEOUT_CYCLES);
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WD_LAST =
        WD_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_e         state_q;
    logic           port_q;
    logic [WDW-1:0] wdog_q;

    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;

    logic        i_rvalid_q;
    logic [31:0] i_rdata_q;
    logic        d_rvalid_q;
    logic [31:0] d_rdata_q;
    logic        d_err_q;

    logic [1:0]  arb_req;
    logic [1:0]  arb_gnt;
    logic        idle;
    logic        grant;
    bus_req_t    req_d;

    logic        expire;
    logic        term;
    logic        bus_err;
    logic [31:0] rdata_d;

    assign idle    = (state_q == IDLE);
    assign arb_req = {bus.data_req_i, bus.instr_req_i};
    assign grant   = idle && (|arb_gnt);

    flexbex_rr_arb2 u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (arb_req),
        .prio_i    (DATA_PRIORITY),
        .gnt_stb_i (grant),
        .gnt_o     (arb_gnt)
    );

    always_comb begin
        req_d = '0;
        unique case (1'b1)
            arb_gnt[PORT_DATA]: begin
                req_d.port = PORT_DATA;
                req_d.we   = bus.data_we_i;
                req_d.sel  = bus.data_be_i;
                req_d.adr  = word_adr(bus.data_addr_i);
                req_d.dat  = bus.data_we_i ? bus.data_wdata_i : 32'd0;
            end
            arb_gnt[PORT_INSTR]: begin
                req_d.port = PORT_INSTR;
                req_d.we   = 1'b0;
                req_d.sel  = SEL_ALL;
                req_d.adr  = word_adr(bus.instr_addr_i);
                req_d.dat  = 32'd0;
            end
            default: req_d = '0;
        endcase
    end

    // err beats ack; ack in the expiry cycle still counts as success
    assign expire  = WD_EN && (32'(wdog_q) == WD_LAST);
    assign term    = bus.wbm_ack_i || bus.wbm_err_i || expire;
    assign bus_err = bus.wbm_err_i || (expire && !bus.wbm_ack_i);
    assign rdata_d = bus_err ? ERR_RDATA : bus.wbm_dat_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            port_q     <= PORT_INSTR;
            wdog_q     <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= 32'd0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= 32'd0;
            d_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        port_q  <= req_d.port;
                        we_q    <= req_d.we;
                        sel_q   <= req_d.sel;
                        adr_q   <= req_d.adr;
                        dat_q   <= req_d.dat;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        wdog_q  <= '0;
                        state_q <= BUS;
                    end
                end
                BUS: begin
                    if (term) begin
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        state_q <= RESP;
                        if (port_q == PORT_DATA) begin
                            d_rvalid_q <= 1'b1;
                            d_rdata_q  <= rdata_d;
                            d_err_q    <= bus_err;
                        end else begin
                            i_rvalid_q <= 1'b1;
                            i_rdata_q  <= rdata_d;
                        end
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                RESP: begin
                    i_rvalid_q <= 1'b0;
                    d_rvalid_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.instr_gnt_o    = idle && arb_gnt[PORT_INSTR];
    assign bus.data_gnt_o     = idle && arb_gnt[PORT_DATA];
    assign bus.instr_rvalid_o = i_rvalid_q;
    assign bus.instr_rdata_o  = i_rdata_q;
    assign bus.data_rvalid_o  = d_rvalid_q;
    assign bus.data_rdata_o   = d_rdata_q;
    assign bus.data_err_o     = d_err_q;

    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = stb_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_flexbex_wb_bridge.sv
// Directed bench for flexbex_wb_bridge: round-robin and data-priority
// instances share stimulus; responses checked against a scoreboard.
module tb_flexbex_wb_bridge;

    import flexbex_bus_pkg::*;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t sbq[$];
    exp_t mon_e;
    logic g0[$];
    logic g1[$];
    int   rv_seen  = 0;
    int   stb_cur  = 0;
    int   stb_last = 0;
    int   rv_before;

    int          s_wait  = 0;
    int          s_cnt   = 0;
    bit          s_hang  = 1'b0;
    bit          s_ack   = 1'b1;
    bit          s_err   = 1'b0;
    logic [31:0] s_rdata = 32'd0;

    flexbex_wb_bridge_if bi0 ();
    flexbex_wb_bridge_if bi1 ();

    flexbex_wb_bridge #(
        .TIMEOUT_CYCLES (4),
        .DATA_PRIORITY  (1'b0)
    ) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bi0)
    );

    flexbex_wb_bridge #(
        .TIMEOUT_CYCLES (4),
        .DATA_PRIORITY  (1'b1)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bi1)
    );

    assign bi1.instr_req_i  = bi0.instr_req_i;
    assign bi1.instr_addr_i = bi0.instr_addr_i;
    assign bi1.data_req_i   = bi0.data_req_i;
    assign bi1.data_we_i    = bi0.data_we_i;
    assign bi1.data_be_i    = bi0.data_be_i;
    assign bi1.data_addr_i  = bi0.data_addr_i;
    assign bi1.data_wdata_i = bi0.data_wdata_i;
    assign bi1.wbm_dat_i    = bi0.wbm_dat_i;
    assign bi1.wbm_ack_i    = bi0.wbm_ack_i;
    assign bi1.wbm_err_i    = bi0.wbm_err_i;

    task automatic chk32(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic void push(input logic p, input logic [31:0] r,
                                 input logic e);
        exp_t x;
        x.port  = p;
        x.rdata = r;
        x.err   = e;
        sbq.push_back(x);
    endfunction

    // Wishbone slave: terminates after s_wait wait states unless hung
    initial begin
        bi0.wbm_ack_i = 1'b0;
        bi0.wbm_err_i = 1'b0;
        bi0.wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (bi0.wbm_cyc_o === 1'b1 && bi0.wbm_stb_o === 1'b1) begin
                if (!s_hang && s_cnt == s_wait) begin
                    bi0.wbm_ack_i = s_ack;
                    bi0.wbm_err_i = s_err;
                    bi0.wbm_dat_i = s_rdata;
                end else begin
                    bi0.wbm_ack_i = 1'b0;
                    bi0.wbm_err_i = 1'b0;
                end
                s_cnt++;
                stb_cur++;
            end else begin
                bi0.wbm_ack_i = 1'b0;
                bi0.wbm_err_i = 1'b0;
                s_cnt = 0;
                if (stb_cur != 0) begin
                    stb_last = stb_cur;
                    stb_cur  = 0;
                end
            end
        end
    end

    // response monitor against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (bi0.instr_rvalid_o === 1'b1 || bi0.data_rvalid_o === 1'b1) begin
                rv_seen++;
                chk1("rsp_expected", sbq.size() != 0, 1'b1);
                if (sbq.size() != 0) begin
                    mon_e = sbq.pop_front();
                    chk1("rsp_instr_rvalid", bi0.instr_rvalid_o, !mon_e.port);
                    chk1("rsp_data_rvalid", bi0.data_rvalid_o, mon_e.port);
                    if (mon_e.port) begin
                        chk32("rsp_data_rdata", bi0.data_rdata_o, mon_e.rdata);
                        chk1("rsp_data_err", bi0.data_err_o, mon_e.err);
                    end else begin
                        chk32("rsp_instr_rdata", bi0.instr_rdata_o, mon_e.rdata);
                    end
                end
            end
        end
    end

    // grant logger for both instances
    initial begin
        forever begin
            @(negedge clk);
            if (bi0.instr_gnt_o === 1'b1) g0.push_back(PORT_INSTR);
            if (bi0.data_gnt_o === 1'b1) g0.push_back(PORT_DATA);
            if (bi1.instr_gnt_o === 1'b1) g1.push_back(PORT_INSTR);
            if (bi1.data_gnt_o === 1'b1) g1.push_back(PORT_DATA);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic do_req(input string tag, input logic p, input logic we,
                          input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd);
        bit ok = 1'b0;
        if (p) begin
            bi0.data_req_i   = 1'b1;
            bi0.data_we_i    = we;
            bi0.data_be_i    = be;
            bi0.data_addr_i  = addr;
            bi0.data_wdata_i = wd;
        end else begin
            bi0.instr_req_i  = 1'b1;
            bi0.instr_addr_i = addr;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((p ? bi0.data_gnt_o : bi0.instr_gnt_o) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk1({tag, "_gnt"}, ok, 1'b1);
        @(posedge clk);
        #1;
        bi0.instr_req_i = 1'b0;
        bi0.data_req_i  = 1'b0;
    endtask

    task automatic check_bus(input string tag, input logic [31:0] adr,
                             input logic [3:0] sel, input logic we,
                             input logic [31:0] dat);
        @(negedge clk);
        chk1({tag, "_stb"}, bi0.wbm_stb_o, 1'b1);
        chk1({tag, "_cyc"}, bi0.wbm_cyc_o, 1'b1);
        chk32({tag, "_adr"}, bi0.wbm_adr_o, adr);
        chk32({tag, "_sel"}, 32'(bi0.wbm_sel_o), 32'(sel));
        chk1({tag, "_we"}, bi0.wbm_we_o, we);
        chk32({tag, "_dat"}, bi0.wbm_dat_o, dat);
    endtask

    task automatic wait_idle(input string tag);
        @(posedge clk);
        for (int i = 0; i < 60 && sbq.size() != 0; i++) @(posedge clk);
        chk32({tag, "_drain"}, sbq.size(), 32'd0);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bi0.instr_req_i  = 1'b0;
        bi0.instr_addr_i = 32'd0;
        bi0.data_req_i   = 1'b0;
        bi0.data_we_i    = 1'b0;
        bi0.data_be_i    = 4'h0;
        bi0.data_addr_i  = 32'd0;
        bi0.data_wdata_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk1("rst_instr_gnt", bi0.instr_gnt_o, 1'b0);
        chk1("rst_data_gnt", bi0.data_gnt_o, 1'b0);
        chk1("rst_instr_rvalid", bi0.instr_rvalid_o, 1'b0);
        chk1("rst_data_rvalid", bi0.data_rvalid_o, 1'b0);
        chk32("rst_instr_rdata", bi0.instr_rdata_o, 32'd0);
        chk32("rst_data_rdata", bi0.data_rdata_o, 32'd0);
        chk1("rst_data_err", bi0.data_err_o, 1'b0);
        chk1("rst_cyc", bi0.wbm_cyc_o, 1'b0);
        chk1("rst_stb", bi0.wbm_stb_o, 1'b0);
        chk1("rst_we", bi0.wbm_we_o, 1'b0);
        chk32("rst_sel", 32'(bi0.wbm_sel_o), 32'd0);
        chk32("rst_adr", bi0.wbm_adr_o, 32'd0);
        chk32("rst_dat", bi0.wbm_dat_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // both ports request continuously
        g0.delete();
        g1.delete();
        s_wait  = 0;
        s_rdata = 32'hA5A5_0001;
        push(PORT_INSTR, 32'hA5A5_0001, 1'b0);
        push(PORT_DATA, 32'hA5A5_0001, 1'b0);
        push(PORT_INSTR, 32'hA5A5_0001, 1'b0);
        push(PORT_DATA, 32'hA5A5_0001, 1'b0);
        bi0.instr_req_i  = 1'b1;
        bi0.instr_addr_i = 32'h0000_0400;
        bi0.data_req_i   = 1'b1;
        bi0.data_we_i    = 1'b0;
        bi0.data_be_i    = 4'hF;
        bi0.data_addr_i  = 32'h0000_0504;
        for (int i = 0; i < 40 && g0.size() < 4; i++) @(negedge clk);
        @(posedge clk);
        #1;
        bi0.instr_req_i = 1'b0;
        bi0.data_req_i  = 1'b0;
        wait_idle("rr");
        chk32("rr_gnt_count", g0.size(), 32'd4);
        chk32("prio_gnt_count", g1.size(), 32'd4);
        while (g0.size() < 4) g0.push_back(1'bx);
        while (g1.size() < 4) g1.push_back(1'bx);
        for (int i = 0; i < 4; i++) begin
            chk1($sformatf("rr_gnt%0d", i), g0[i], (i % 2 == 1));
            chk1($sformatf("prio_gnt%0d", i), g1[i], PORT_DATA);
        end

        // single data write, zero-wait ack
        s_rdata = 32'd0;
        push(PORT_DATA, 32'd0, 1'b0);
        do_req("wr", PORT_DATA, 1'b1, 4'b1100, 32'h3000_0006, 32'hDEAD_BEEF);
        check_bus("wr", 32'h3000_0004, 4'b1100, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk1("wr_rvalid_next", bi0.data_rvalid_o, 1'b1);
        chk1("wr_err", bi0.data_err_o, 1'b0);
        wait_idle("wr");

        // fetch with three wait states
        s_wait  = 3;
        s_rdata = 32'h0000_0013;
        push(PORT_INSTR, 32'h0000_0013, 1'b0);
        do_req("if", PORT_INSTR, 1'b0, 4'h0, 32'h0000_0100, 32'd0);
        check_bus("if", 32'h0000_0100, 4'hF, 1'b0, 32'd0);
        wait_idle("if");
        chk32("if_stb_len", stb_last, 32'd4);

        // hung slave, watchdog expiry
        s_hang        = 1'b1;
        bi0.wbm_dat_i = 32'hBAD0_BAD0;
        push(PORT_DATA, 32'd0, 1'b1);
        do_req("to", PORT_DATA, 1'b0, 4'hF, 32'h0000_0200, 32'h1111_1111);
        check_bus("to", 32'h0000_0200, 4'hF, 1'b0, 32'd0);
        wait_idle("to");
        chk32("to_stb_len", stb_last, 32'd4);
        s_hang = 1'b0;

        // ack and err together on a fetch
        s_wait  = 0;
        s_err   = 1'b1;
        s_rdata = 32'h1234_5678;
        push(PORT_INSTR, ERR_RDATA, 1'b1);
        do_req("ae", PORT_INSTR, 1'b0, 4'h0, 32'h0000_0300, 32'd0);
        wait_idle("ae");
        chk1("data_err_hold", bi0.data_err_o, 1'b1);
        s_err = 1'b0;

        // ack in the watchdog expiry cycle
        s_wait  = 3;
        s_rdata = 32'hCAFE_F00D;
        push(PORT_DATA, 32'hCAFE_F00D, 1'b0);
        do_req("ax", PORT_DATA, 1'b0, 4'b0011, 32'h0000_0700, 32'd0);
        check_bus("ax", 32'h0000_0700, 4'b0011, 1'b0, 32'd0);
        wait_idle("ax");
        chk32("ax_stb_len", stb_last, 32'd4);

        // reset in the second BUS cycle of a fetch
        s_hang    = 1'b1;
        rv_before = rv_seen;
        do_req("rb", PORT_INSTR, 1'b0, 4'h0, 32'h0000_0600, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk1("rb_stb_bus2", bi0.wbm_stb_o, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("rb_cyc_low", bi0.wbm_cyc_o, 1'b0);
        chk1("rb_stb_low", bi0.wbm_stb_o, 1'b0);
        repeat (6) @(negedge clk);
        chk32("rb_no_rvalid", rv_seen, rv_before);
        s_hang = 1'b0;

        // after reset the conflict goes to instr
        @(posedge clk);
        #1;
        g0.delete();
        g1.delete();
        s_wait  = 0;
        s_rdata = 32'h0BAD_F00D;
        push(PORT_INSTR, 32'h0BAD_F00D, 1'b0);
        bi0.instr_req_i  = 1'b1;
        bi0.instr_addr_i = 32'h0000_0800;
        bi0.data_req_i   = 1'b1;
        bi0.data_we_i    = 1'b0;
        bi0.data_be_i    = 4'hF;
        bi0.data_addr_i  = 32'h0000_0900;
        for (int i = 0; i < 20 && g0.size() < 1; i++) @(negedge clk);
        @(posedge clk);
        #1;
        bi0.instr_req_i = 1'b0;
        bi0.data_req_i  = 1'b0;
        wait_idle("pr");
        chk32("pr_gnt_count", g0.size(), 32'd1);
        if (g0.size() == 0) g0.push_back(1'bx);
        if (g1.size() == 0) g1.push_back(1'bx);
        chk1("pr_rr_first", g0[0], PORT_INSTR);
        chk1("pr_prio_first", g1[0], PORT_DATA);

        repeat (3) @(negedge clk);
        chk32("sb_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flexbex_wb_bridge.md
# flexbex_wb_bridge

Bus bridge directly downstream of the flexbex core wrapper: merges the core's instruction port and data port (req/gnt/rvalid protocol) onto a single Wishbone classic master toward the SoC interconnect. One transaction is outstanding at a time. A 2-way arbiter selects between the ports, and a watchdog terminates hung bus cycles. A bus error or timeout is returned to the originating port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles a Wishbone cycle may wait for ack/err; 0 disables the watchdog.
- DATA_PRIORITY, 0: 1 = the data port always wins; 0 = round-robin.

Ports. One clock; reset is synchronous and active-high.
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_i  in  1  instruction fetch request
- instr_addr_i  in  32  fetch address
- instr_gnt_o  out  1  request accepted
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetched word
- data_req_i  in  1  data request
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  request accepted
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  read data
- data_err_o  out  1  error, qualified by data_rvalid_o
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone control
- wbm_sel_o  out  4  byte select
- wbm_adr_o  out  32  word-aligned address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i, wbm_err_i  in  1 each  termination

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: if any req is high, grant exactly one port. The gnt is combinational from req in IDLE only. Latch the port ID, we, sel, address, and wdata. Go to BUS.
- Arbitration:
  - If DATA_PRIORITY=1, data wins.
  - Otherwise round-robin: on conflict, the port not granted last wins.
  - The pointer updates only on a grant. After reset it favours instr.
- Instruction transactions: we=0, sel=4'hF.
- Data transactions: sel=data_be_i. wbm_dat_o is driven only for writes and is 0 otherwise.
- wbm_adr_o = {addr[31:2], 2'b00}.
- BUS:
  - cyc=stb=1 from registered state.
  - Terminate on ack, err, or watchdog expiry.
  - Capture rdata and the error flag. Go to RESP.
- RESP: drive rvalid=1 on the latched port for exactly one cycle, with cyc/stb=0 and no gnt. Go to IDLE.
- Error responses:
  - Data port: data_err_o=1, data_rdata_o=0.
  - Instruction port: instr_rdata_o=32'h0000_0000, which the core decodes as an illegal instruction.
- Simultaneous termination events:
  - ack and err in the same cycle: err wins.
  - ack in the expiry cycle: ack wins, no error.
- Watchdog: the counter clears on entering BUS and increments each BUS cycle without termination. When it reaches TIMEOUT_CYCLES, the cycle is abandoned as an error.
- rdata/err outputs hold their value until the next response.

## Timing
- Reset values of all outputs: gnt=0, rvalid=0, cyc=stb=we=0, sel=0, adr=0, dat_o=0, rdata=0, err=0. The state is IDLE and the arbiter pointer favours instr.
- Reset asserted mid-BUS: cyc/stb drop at the next edge, no rvalid is issued, and the transaction is lost.
- Grant in cycle T. stb is high from T+1.
- Zero-wait ack in T+1 gives rvalid in T+2. The next grant comes in T+3 at the earliest, so throughput is 1 transaction per 3 cycles minimum.
- Timeout: stb high for TIMEOUT_CYCLES cycles, then an error rvalid on the following cycle.
- A req that is deasserted before being granted is legal. No state change occurs.

## Structure
- Shared package flexbex_bus_pkg holds:
  - the state enum (IDLE/BUS/RESP);
  - the port-ID constants (PORT_INSTR=0, PORT_DATA=1);
  - SEL_ALL=4'hF;
  - ERR_RDATA=32'h0.
- Sub-module flexbex_rr_arb2: 2-requester round-robin with a priority-override input and a pointer update on the grant strobe.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

## Test plan
- Single data write: addr=32'h3000_0006, be=4'b1100, wdata=32'hDEAD_BEEF, ack in first BUS cycle.
  - Required: wbm_adr_o=32'h3000_0004, sel=4'b1100, we=1.
  - Required: data_rvalid_o one cycle later with err=0.
- Instruction fetch: addr=32'h100, slave returns 32'h0000_0013 after 3 wait cycles.
  - Required: instr_rvalid_o with rdata=32'h13, sel=4'hF.
- Both ports request continuously, DATA_PRIORITY=0.
  - Required: grants alternate instr, data, instr, data.
  - Repeat with DATA_PRIORITY=1. Required: data is always granted.
- Slave never terminates, TIMEOUT_CYCLES=4.
  - Required: stb high for exactly 4 cycles.
  - Required: data_rvalid_o with data_err_o=1 and rdata=0.
- ack and err asserted together on an instruction read.
  - Required: error response with instr_rdata_o=0.
  - Required: ack alone at timeout expiry yields err=0.
- rst_i pulsed in the second BUS cycle.
  - Required: cyc/stb low at the next edge and no rvalid.
  - Required: a subsequent request with both ports active is granted to instr.
